dmem_ctrl: RTL and testbench

Data-memory controller for the Memory pipeline stage. It keeps one SDRAM page resident in the on-chip data memory (dmem) and checks every load/store address against the resident page tag. On a miss it stalls the pipeline and sequences a page fill from the SDRAM controller. While the fill runs it hands the dmem port to the SDRAM controller through the `d_sb` mux select, then returns the port to the LS path.

---
 rtl/dmem_ctrl_if.sv | 32 +++
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Signal bundle between dmem_ctrl, the Memory-stage LS slot and the SDRAM controller.
// The master modport is the controller; the slave modport is the pipeline/SDRAM side.
interface dmem_ctrl_if;
  // LS slot
  logic        ls_req;
  logic        R_nW;
  logic [24:0] sdram_addr;

  // Request/busy handshake: request is a level held until busy is seen high,
  // then the controller waits for busy low before treating the transfer as done.
  // start_addr and wr_back are stable for the whole request.
  logic        busy;
  logic        request;
  logic        wr_back;
  logic [24:0] start_addr;
  logic [24:0] length;

  // dmem port
  logic [15:0] dmc_addr;
  logic        stall;
  logic        d_sb;

  modport master (
    input  ls_req, R_nW, sdram_addr, busy,
    output request, wr_back, start_addr, length, dmc_addr, stall, d_sb
  );

  modport slave (
    output ls_req, R_nW, sdram_addr, busy,
    input  request, wr_back, start_addr, length, dmc_addr, stall, d_sb
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-page data-memory controller: tag check, miss stall and SDRAM page fill.
// Define DMEM_WRITEBACK_EN to track dirty pages and write them back before a fill.
module dmem_ctrl #(
  parameter int PAGE_BITS = 16
) (
  input  logic        ref_clk,
  input  logic        rst,
  dmem_ctrl_if.master bus,
  output logic [2:0]  o_dbg_state
);

  localparam int TAG_W = 25 - PAGE_BITS;

`ifdef DMEM_WRITEBACK_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB_REQ    = 3'd1,
    WB_WAIT   = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4
  } state_t;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_fill_tag;
  logic               r_valid;
  logic [24:0]        r_start_addr;

  logic [TAG_W-1:0]   w_tag_in;
  logic               w_hit;
  logic               w_miss;
  logic               w_request;
  logic               w_stall;
  logic               w_dsb;
  logic               w_go_fill;
  logic               w_fill_done;
  logic [15:0]        w_dmc_addr;

`ifdef DMEM_WRITEBACK_EN
  logic               r_dirty;
  logic               r_wr_back;
  logic               w_go_wb;
  logic               w_wb_done;
  logic               w_store_hit;
`else
  logic               w_unused_rnw;
`endif

  assign w_tag_in = bus.sdram_addr[24:PAGE_BITS];
  assign w_hit    = r_valid && (w_tag_in == r_tag);
  assign w_miss   = bus.ls_req && !w_hit;

  always_comb begin
    w_dmc_addr                = '0;
    w_dmc_addr[PAGE_BITS-1:0] = bus.sdram_addr[PAGE_BITS-1:0];
  end

  always_comb begin
    w_next      = r_state;
    w_request   = 1'b0;
    w_stall     = 1'b1;
    w_dsb       = 1'b0;
    w_go_fill   = 1'b0;
    w_fill_done = 1'b0;
`ifdef DMEM_WRITEBACK_EN
    w_go_wb     = 1'b0;
    w_wb_done   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_stall = w_miss;
        w_dsb   = 1'b1;
        if (w_miss && !bus.busy) begin
`ifdef DMEM_WRITEBACK_EN
          if (r_valid && r_dirty) begin
            w_next  = WB_REQ;
            w_go_wb = 1'b1;
          end else begin
            w_next    = FILL_REQ;
            w_go_fill = 1'b1;
          end
`else
          w_next    = FILL_REQ;
          w_go_fill = 1'b1;
`endif
        end
      end
`ifdef DMEM_WRITEBACK_EN
      WB_REQ: begin
        w_request = 1'b1;
        if (bus.busy) w_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (!bus.busy) begin
          w_next    = FILL_REQ;
          w_wb_done = 1'b1;
        end
      end
`endif
      FILL_REQ: begin
        w_request = 1'b1;
        if (bus.busy) w_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (!bus.busy) begin
          w_next      = IDLE;
          w_fill_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The miss tag is captured when the miss is accepted so ls_req may drop mid-fill.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      r_tag        <= '0;
      r_fill_tag   <= '0;
      r_valid      <= 1'b0;
      r_start_addr <= '0;
    end else begin
      if (w_go_fill) begin
        r_fill_tag   <= w_tag_in;
        r_start_addr <= {w_tag_in, {PAGE_BITS{1'b0}}};
      end
`ifdef DMEM_WRITEBACK_EN
      if (w_go_wb) begin
        r_fill_tag   <= w_tag_in;
        r_start_addr <= {r_tag, {PAGE_BITS{1'b0}}};
      end
      if (w_wb_done) begin
        r_start_addr <= {r_fill_tag, {PAGE_BITS{1'b0}}};
      end
`endif
      if (w_fill_done) begin
        r_tag   <= r_fill_tag;
        r_valid <= 1'b1;
      end
    end
  end

`ifdef DMEM_WRITEBACK_EN
  assign w_store_hit = (r_state == IDLE) && bus.ls_req && !bus.R_nW && w_hit;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      r_dirty   <= 1'b0;
      r_wr_back <= 1'b0;
    end else begin
      if (w_wb_done || w_fill_done) r_dirty <= 1'b0;
      else if (w_store_hit)         r_dirty <= 1'b1;
      if (w_go_wb)                  r_wr_back <= 1'b1;
      else if (w_go_fill || w_wb_done) r_wr_back <= 1'b0;
    end
  end

  assign bus.wr_back = r_wr_back;
`else
  assign w_unused_rnw = bus.R_nW;
  assign bus.wr_back  = 1'b0;
`endif

  // Reset forces IDLE; masking stall keeps the pipeline free while rst is held.
  assign bus.request    = w_request;
  assign bus.stall      = w_stall && !rst;
  assign bus.d_sb       = w_dsb;
  assign bus.start_addr = r_start_addr;
  assign bus.length     = 25'(1) << PAGE_BITS;
  assign bus.dmc_addr   = w_dmc_addr;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl with PAGE_BITS=8: page-level reference model, expected request queue
// and a monitor checking every SDRAM request against it.
module tb_dmem_ctrl;

  logic        ref_clk = 1'b0;
  logic        rst;
  logic [2:0]  dbg_state;
  logic        ext_busy;
  logic        model_busy;
  int          busy_cnt;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic        prev_req = 1'b0;

  logic [25:0] exp_q[$];   // {wr_back, start_addr}

  logic        m_valid;
  logic [16:0] m_tag;
  logic        m_dirty;

  dmem_ctrl_if bus();

  dmem_ctrl #(.PAGE_BITS(8)) dut (
    .ref_clk     (ref_clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 ref_clk = ~ref_clk;

  // SDRAM controller stand-in: accepts a request when idle and stays busy 10 cycles.
  always @(posedge ref_clk) begin
    if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
    else if (bus.request) busy_cnt <= 10;
  end
  assign model_busy = (busy_cnt > 0);
  assign bus.busy   = model_busy | ext_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: each new request must match the next expected transfer.
  always @(negedge ref_clk) begin
    logic [25:0] e;
    if (!rst) begin
      if (bus.request && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_request: got start_addr 0x%0h wr_back %0d, required none",
                   bus.start_addr, bus.wr_back);
        end else begin
          e = exp_q.pop_front();
          check("req_start_addr", 32'(bus.start_addr), 32'(e[24:0]));
          check("req_wr_back", 32'(bus.wr_back), 32'(e[25]));
          check("req_length", 32'(bus.length), 32'h100);
        end
      end
      if (bus.request) begin
        check("req_stall", 32'(bus.stall), 32'd1);
        check("req_d_sb", 32'(bus.d_sb), 32'd0);
      end
    end
    prev_req = bus.request;
  end

  // Called at posedge+1; returns at posedge+1 with ls_req low.
  task automatic do_access(input logic [24:0] a, input logic rnw, input bit drop_mid);
    logic [16:0] pg;
    logic        hit;
    logic        busy0;
    int          n;
    pg  = a[24:8];
    hit = m_valid && (pg == m_tag);
    bus.ls_req     = 1'b1;
    bus.R_nW       = rnw;
    bus.sdram_addr = a;
    #1;
    if (hit) begin
      check("hit_stall", 32'(bus.stall), 32'd0);
      check("hit_d_sb", 32'(bus.d_sb), 32'd1);
      check("hit_dmc_addr", 32'(bus.dmc_addr), 32'(a[7:0]));
`ifdef DMEM_WRITEBACK_EN
      if (!rnw) m_dirty = 1'b1;
`endif
      @(posedge ref_clk); #1;
      bus.ls_req = 1'b0;
      return;
    end
    check("miss_stall_c0", 32'(bus.stall), 32'd1);
    check("miss_d_sb_c0", 32'(bus.d_sb), 32'd1);
`ifdef DMEM_WRITEBACK_EN
    if (m_valid && m_dirty) exp_q.push_back({1'b1, m_tag, 8'h00});
`endif
    exp_q.push_back({1'b0, pg, 8'h00});
    busy0 = bus.busy;
    @(posedge ref_clk); #1;
    if (!busy0) begin
      check("miss_req_c1", 32'(bus.request), 32'd1);
      check("miss_d_sb_c1", 32'(bus.d_sb), 32'd0);
    end
    if (drop_mid) begin
      n = 0;
      while (!(bus.busy && !bus.request && !bus.wr_back) && n < 300) begin
        @(posedge ref_clk); #1;
        n++;
      end
      if (n >= 300) timeout("reach_fill_wait");
      bus.ls_req = 1'b0;
      n = 0;
      while (bus.busy && n < 300) begin
        @(posedge ref_clk); #1;
        n++;
      end
      if (n >= 300) timeout("busy_fall");
      @(posedge ref_clk); #1;
      check("drop_stall", 32'(bus.stall), 32'd0);
      check("drop_d_sb", 32'(bus.d_sb), 32'd1);
      m_valid = 1'b1;
      m_tag   = pg;
      m_dirty = 1'b0;
      return;
    end
    n = 0;
    while (bus.stall && n < 300) begin
      @(posedge ref_clk); #1;
      n++;
    end
    if (n >= 300) timeout("miss_stall_release");
    check("fill_d_sb", 32'(bus.d_sb), 32'd1);
    check("fill_dmc_addr", 32'(bus.dmc_addr), 32'(a[7:0]));
    m_valid = 1'b1;
    m_tag   = pg;
    m_dirty = 1'b0;
`ifdef DMEM_WRITEBACK_EN
    if (!rnw) m_dirty = 1'b1;
`endif
    @(posedge ref_clk); #1;
    bus.ls_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [24:0] ra;
    busy_cnt       = 0;
    ext_busy       = 1'b0;
    rst            = 1'b1;
    bus.ls_req     = 1'b0;
    bus.R_nW       = 1'b1;
    bus.sdram_addr = '0;
    m_valid = 1'b0;
    m_tag   = '0;
    m_dirty = 1'b0;
    repeat (3) @(posedge ref_clk);
    #1;
    check("rst_request", 32'(bus.request), 32'd0);
    check("rst_wr_back", 32'(bus.wr_back), 32'd0);
    check("rst_start_addr", 32'(bus.start_addr), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_d_sb", 32'(bus.d_sb), 32'd1);
    check("rst_length", 32'(bus.length), 32'h100);
    rst = 1'b0;
    @(posedge ref_clk); #1;

    // First fill, page-end hit, dirtying store, then eviction
    do_access(25'h0000123, 1'b1, 1'b0);
    do_access(25'h00001FF, 1'b1, 1'b0);
    do_access(25'h0000105, 1'b0, 1'b0);
    do_access(25'h0000200, 1'b1, 1'b0);

    // Miss while the SDRAM controller is busy for 5 cycles
    ext_busy       = 1'b1;
    bus.ls_req     = 1'b1;
    bus.R_nW       = 1'b1;
    bus.sdram_addr = 25'h0000345;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("busy_hold_request", 32'(bus.request), 32'd0);
      check("busy_hold_stall", 32'(bus.stall), 32'd1);
      @(posedge ref_clk); #1;
    end
    ext_busy = 1'b0;
    do_access(25'h0000345, 1'b1, 1'b0);

    // ls_req drops mid-fill; page must still become resident
    do_access(25'h0000456, 1'b1, 1'b1);
    do_access(25'h00004AB, 1'b1, 1'b0);

    // Reset during FILL_WAIT
    bus.ls_req     = 1'b1;
    bus.R_nW       = 1'b1;
    bus.sdram_addr = 25'h0000567;
    exp_q.push_back({1'b0, 17'h00005, 8'h00});
    n = 0;
    #1;
    while (!(bus.busy && !bus.request) && n < 300) begin
      @(posedge ref_clk); #1;
      n++;
    end
    if (n >= 300) timeout("rst_reach_fill_wait");
    rst = 1'b1;
    #1;
    check("rst_mid_request", 32'(bus.request), 32'd0);
    check("rst_mid_stall", 32'(bus.stall), 32'd0);
    check("rst_mid_d_sb", 32'(bus.d_sb), 32'd1);
    @(posedge ref_clk); #1;
    rst        = 1'b0;
    bus.ls_req = 1'b0;
    m_valid    = 1'b0;
    m_dirty    = 1'b0;
    n = 0;
    while (bus.busy && n < 300) begin
      @(posedge ref_clk); #1;
      n++;
    end
    if (n >= 300) timeout("rst_busy_fall");
    do_access(25'h0000100, 1'b1, 1'b0);

    // Random loads/stores across a few pages, including the top of the address space
    for (int k = 0; k < 40; k++) begin
      ra[7:0]  = 8'($urandom_range(0, 255));
      ra[24:8] = ($urandom_range(0, 7) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 3));
      do_access(ra, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge ref_clk); #1;
      end
    end

    repeat (3) @(posedge ref_clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
